// File: rtl/alu_cmd_sequencer_if.sv
// Bundle between the SIMD mul/add command sequencer, its command source, the vector register file and the ALU.
// Optional lane_ovf signal is present only when ALU_SEQ_LANE_OVF_EN is defined.
interface alu_cmd_sequencer_if #(
    parameter int ADDR_W = 3,
    parameter int LANES  = 16
);
    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_* must be stable while cmd_valid is high and are ignored whenever cmd_ready is low.
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [ADDR_W-1:0]     cmd_src1;
    logic [ADDR_W-1:0]     cmd_src2;
    logic [ADDR_W-1:0]     cmd_dst_lo;
    logic [ADDR_W-1:0]     cmd_dst_hi;

    logic [ADDR_W-1:0]     rf_rd_addr1;
    logic [ADDR_W-1:0]     rf_rd_addr2;
    logic [32*LANES-1:0]   rf_rd_data1;
    logic [32*LANES-1:0]   rf_rd_data2;
    logic                  rf_wr_en;
    logic [ADDR_W-1:0]     rf_wr_addr;
    logic [32*LANES-1:0]   rf_wr_data;

    logic                  alu_mul_add;
    logic [32*LANES-1:0]   alu_in1;
    logic [32*LANES-1:0]   alu_in2;
    logic [64*LANES-1:0]   alu_out;

    logic                  busy;
    logic                  done;
`ifdef ALU_SEQ_LANE_OVF_EN
    logic [LANES-1:0]      lane_ovf;
`endif

    modport slave (
        input  cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst_lo, cmd_dst_hi,
        input  rf_rd_data1, rf_rd_data2, alu_out,
        output cmd_ready, rf_rd_addr1, rf_rd_addr2, rf_wr_en, rf_wr_addr, rf_wr_data,
        output alu_mul_add, alu_in1, alu_in2, busy, done
`ifdef ALU_SEQ_LANE_OVF_EN
        , output lane_ovf
`endif
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src1, cmd_src2, cmd_dst_lo, cmd_dst_hi,
        output rf_rd_data1, rf_rd_data2, alu_out,
        input  cmd_ready, rf_rd_addr1, rf_rd_addr2, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  alu_mul_add, alu_in1, alu_in2, busy, done
`ifdef ALU_SEQ_LANE_OVF_EN
        , input lane_ovf
`endif
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Six-state sequencer: read two vector operands, run the SIMD mul/add ALU, write L then H back.
// Define ALU_SEQ_LANE_OVF_EN to add the per-lane signed-32-bit overflow flags (lane_ovf).
module alu_cmd_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int LANES    = 16
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus,
    output logic [2:0]          dbg_state
);
    localparam int W = 32 * LANES;

    generate
        if ((2 ** ADDR_W) < NUM_REGS) begin : g_bad_addr_w
            $error("ADDR_W too small for NUM_REGS");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_WB_LO = 3'd4,
        S_WB_HI = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              cmd_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [W-1:0]      wr_data_q;
    logic [ADDR_W-1:0] rd_addr1_q;
    logic [ADDR_W-1:0] rd_addr2_q;
    logic              op_q;
    logic [ADDR_W-1:0] dst_lo_q;
    logic [ADDR_W-1:0] dst_hi_q;
    logic              alu_mul_add_q;
    logic [W-1:0]      alu_in1_q;
    logic [W-1:0]      alu_in2_q;
    logic [W-1:0]      result_hi_q;
    logic              accept;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid && cmd_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  state_d = S_LATCH;
            S_LATCH: state_d = S_EXEC;
            S_EXEC:  state_d = S_WB_LO;
            S_WB_LO: state_d = S_WB_HI;
            S_WB_HI: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake/strobe outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_en_q     <= 1'b0;
        end else begin
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_q == S_WB_HI);
            wr_en_q     <= (state_d == S_WB_LO) || (state_d == S_WB_HI);
        end
    end

    // L goes straight into the write-data register at the end of EXEC; only H needs holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr1_q    <= '0;
            rd_addr2_q    <= '0;
            op_q          <= 1'b0;
            dst_lo_q      <= '0;
            dst_hi_q      <= '0;
            alu_mul_add_q <= 1'b0;
            alu_in1_q     <= '0;
            alu_in2_q     <= '0;
            result_hi_q   <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        rd_addr1_q <= bus.cmd_src1;
                        rd_addr2_q <= bus.cmd_src2;
                        op_q       <= bus.cmd_op;
                        dst_lo_q   <= bus.cmd_dst_lo;
                        dst_hi_q   <= bus.cmd_dst_hi;
                    end
                end
                S_LATCH: begin
                    alu_in1_q     <= bus.rf_rd_data1;
                    alu_in2_q     <= bus.rf_rd_data2;
                    alu_mul_add_q <= op_q;
                end
                S_EXEC: begin
                    result_hi_q <= bus.alu_out[2*W-1:W];
                    wr_addr_q   <= dst_lo_q;
                    wr_data_q   <= bus.alu_out[W-1:0];
                end
                S_WB_LO: begin
                    wr_addr_q <= dst_hi_q;
                    wr_data_q <= result_hi_q;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_SEQ_LANE_OVF_EN
    logic [LANES-1:0] ovf_d;
    logic [LANES-1:0] ovf_q;

    // A lane overflows when H is not just the sign extension of L.
    always_comb begin
        ovf_d = '0;
        for (int i = 0; i < LANES; i++) begin
            ovf_d[i] = bus.alu_out[W+32*i +: 32] != {32{bus.alu_out[32*i+31]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (state_q == S_EXEC) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.lane_ovf = ovf_q;
`endif

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rf_wr_en    = wr_en_q;
    assign bus.rf_wr_addr  = wr_addr_q;
    assign bus.rf_wr_data  = wr_data_q;
    assign bus.rf_rd_addr1 = rd_addr1_q;
    assign bus.rf_rd_addr2 = rd_addr2_q;
    assign bus.alu_mul_add = alu_mul_add_q;
    assign bus.alu_in1     = alu_in1_q;
    assign bus.alu_in2     = alu_in2_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: register-file and ALU models, write scoreboard, vector table and corner sequences.
// Build with ALU_SEQ_LANE_OVF_EN defined to also check lane_ovf.
module tb_alu_cmd_sequencer;
    localparam int ADDR_W   = 3;
    localparam int LANES    = 16;
    localparam int NUM_REGS = 8;
    localparam int W        = 32 * LANES;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    int         checks = 0;
    int         failures = 0;

    alu_cmd_sequencer_if #(.ADDR_W(ADDR_W), .LANES(LANES)) bus ();

    alu_cmd_sequencer #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Register file model with registered read and a bench preload port.
    logic [W-1:0]      mem [NUM_REGS];
    logic              pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [W-1:0]      pl_data = '0;

    always @(posedge clk) begin
        bus.rf_rd_data1 <= mem[bus.rf_rd_addr1];
        bus.rf_rd_data2 <= mem[bus.rf_rd_addr2];
        if (bus.rf_wr_en === 1'b1) mem[bus.rf_wr_addr] <= bus.rf_wr_data;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    function automatic logic [63:0] alu_lane(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return op ? (sa + sb) : (sa * sb);
    endfunction

    always_comb begin
        bus.alu_out = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [63:0] r;
            r = alu_lane(bus.alu_mul_add, bus.alu_in1[32*i +: 32], bus.alu_in2[32*i +: 32]);
            bus.alu_out[32*i +: 32]     = r[31:0];
            bus.alu_out[W+32*i +: 32]   = r[63:32];
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: each expected write is {addr, data}, popped when the DUT strobes rf_wr_en.
    logic [ADDR_W+W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d, expected no write", bus.rf_wr_addr);
            end else begin
                logic [ADDR_W+W-1:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", W'(bus.rf_wr_addr), W'(e[ADDR_W+W-1:W]));
                chk("wr_data", bus.rf_wr_data, e[W-1:0]);
            end
        end
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [ADDR_W-1:0] s1, s2, lo, hi);
        bus.cmd_op = op; bus.cmd_src1 = s1; bus.cmd_src2 = s2;
        bus.cmd_dst_lo = lo; bus.cmd_dst_hi = hi;
        bus.cmd_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout: cmd_ready stayed %b, expected 1", tag, bus.cmd_ready);
        end
        @(posedge clk); #1;
    endtask

    // Six cycles after the accepting edge: READ, LATCH, EXEC, WB_LO, WB_HI, IDLE(done).
    task automatic check_phases(input string tag, input logic [LANES-1:0] eovf);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("%s_busy_c%0d", tag, k), W'(bus.busy), W'(k < 5));
            chk($sformatf("%s_ready_c%0d", tag, k), W'(bus.cmd_ready), W'(k == 5));
            chk($sformatf("%s_wren_c%0d", tag, k), W'(bus.rf_wr_en), W'(k == 3 || k == 4));
            chk($sformatf("%s_done_c%0d", tag, k), W'(bus.done), W'(k == 5));
`ifdef ALU_SEQ_LANE_OVF_EN
            if (k == 5) chk({tag, "_lane_ovf"}, W'(bus.lane_ovf), W'(eovf));
`endif
        end
    endtask

    task automatic run_cmd(input string tag, input logic op, input logic [ADDR_W-1:0] s1, s2, lo, hi,
                           input logic [W-1:0] a, b, el, eh, input logic [LANES-1:0] eovf);
        preload(s1, a);
        preload(s2, b);
        exp_q.push_back({lo, el});
        exp_q.push_back({hi, eh});
        issue(op, s1, s2, lo, hi);
        wait_accept(tag);
        bus.cmd_valid = 1'b0;
        check_phases(tag, eovf);
        chk({tag, "_mem_hi"}, mem[hi], eh);
        if (lo != hi) chk({tag, "_mem_lo"}, mem[lo], el);
    endtask

    typedef struct {
        logic              op;
        logic [ADDR_W-1:0] s1, s2, lo, hi;
        logic [31:0]       a, b, el, eh;
        logic              ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0]     ra, rb, rl, rh;
        logic [LANES-1:0] rovf;
        logic             rop;
        logic [63:0]      r;

        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0;
        bus.cmd_src1 = '0; bus.cmd_src2 = '0; bus.cmd_dst_lo = '0; bus.cmd_dst_hi = '0;

        vecs[0] = '{1'b1, 3'd1, 3'd2, 3'd3, 3'd4, 32'd7,        32'hFFFFFFFD, 32'd4,        32'd0,        1'b0};
        vecs[1] = '{1'b0, 3'd1, 3'd2, 3'd5, 3'd6, 32'h40000000, 32'd4,        32'd0,        32'd1,        1'b1};
        vecs[2] = '{1'b1, 3'd2, 3'd2, 3'd2, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0};
        vecs[3] = '{1'b0, 3'd3, 3'd4, 3'd1, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0};
        vecs[4] = '{1'b1, 3'd0, 3'd7, 3'd6, 3'd6, 32'h7FFFFFFF, 32'd1,        32'h80000000, 32'd0,        1'b1};
        vecs[5] = '{1'b0, 3'd5, 3'd6, 3'd7, 3'd1, 32'h80000000, 32'h80000000, 32'd0,        32'h40000000, 1'b1};
        vecs[6] = '{1'b1, 3'd7, 3'd5, 3'd5, 3'd3, 32'h80000000, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b1};
        vecs[7] = '{1'b0, 3'd4, 3'd1, 3'd2, 3'd4, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", W'(bus.cmd_ready), W'(1));
        chk("rst_busy", W'(bus.busy), W'(0));
        chk("rst_wr_en", W'(bus.rf_wr_en), W'(0));
        chk("rst_done", W'(bus.done), W'(0));
        chk("rst_wr_addr", W'(bus.rf_wr_addr), W'(0));
        chk("rst_wr_data", bus.rf_wr_data, '0);
        chk("rst_alu_in1", bus.alu_in1, '0);
        chk("rst_rd_addr1", W'(bus.rf_rd_addr1), W'(0));

        for (int i = 0; i < 8; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].lo, vecs[i].hi,
                    {LANES{vecs[i].a}}, {LANES{vecs[i].b}}, {LANES{vecs[i].el}}, {LANES{vecs[i].eh}},
                    {LANES{vecs[i].ovf}});
        end

        for (int n = 0; n < 3; n++) begin
            rop = 1'(n);
            for (int i = 0; i < LANES; i++) begin
                ra[32*i +: 32] = $urandom_range(32'hFFFFFFFF, 0);
                rb[32*i +: 32] = (i % 4 == 0) ? 32'h80000000 : $urandom_range(32'hFFFFFFFF, 0);
                r = alu_lane(rop, ra[32*i +: 32], rb[32*i +: 32]);
                rl[32*i +: 32] = r[31:0];
                rh[32*i +: 32] = r[63:32];
                rovf[i] = r[63:32] != {32{r[31]}};
            end
            run_cmd($sformatf("rnd%0d", n), rop, 3'd1, 3'd2, 3'd3, 3'd4, ra, rb, rl, rh, rovf);
        end

        // Back-to-back: second command held valid through the first, sources the first's dst_lo.
        preload(3'd1, {LANES{32'd5}});
        preload(3'd2, {LANES{32'd10}});
        exp_q.push_back({3'd3, {LANES{32'd15}}});
        exp_q.push_back({3'd4, {LANES{32'd0}}});
        exp_q.push_back({3'd6, {LANES{32'd75}}});
        exp_q.push_back({3'd7, {LANES{32'd0}}});
        issue(1'b1, 3'd1, 3'd2, 3'd3, 3'd4);
        wait_accept("b2b_a");
        issue(1'b0, 3'd3, 3'd1, 3'd6, 3'd7);
        check_phases("b2b_a", '0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check_phases("b2b_b", '0);
        chk("b2b_mem6", mem[6], {LANES{32'd75}});
        chk("b2b_mem7", mem[7], {LANES{32'd0}});

        // Reset held during WB_LO: the H write and done pulse must never appear.
        preload(3'd6, {LANES{32'h12345678}});
        preload(3'd1, {LANES{32'd3}});
        preload(3'd2, {LANES{32'd4}});
        exp_q.push_back({3'd5, {LANES{32'd7}}});
        issue(1'b1, 3'd1, 3'd2, 3'd5, 3'd6);
        wait_accept("rstwb");
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rstwb_wren_c%0d", k), W'(bus.rf_wr_en), W'(0));
            chk($sformatf("rstwb_done_c%0d", k), W'(bus.done), W'(0));
            chk($sformatf("rstwb_ready_c%0d", k), W'(bus.cmd_ready), W'(1));
            chk($sformatf("rstwb_busy_c%0d", k), W'(bus.busy), W'(0));
        end
        chk("rstwb_mem6", mem[6], {LANES{32'h12345678}});
`ifdef ALU_SEQ_LANE_OVF_EN
        chk("rstwb_lane_ovf", W'(bus.lane_ovf), W'(0));
`endif

        chk("exp_q_empty", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
